instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential LEGv8 instruction encoder and program loader: the encode-side counterpart of the processor's main opcode decoder. It accepts instruction fields (class, registers, immediate) over a valid/ready stream, packs each into a 32-bit LEGv8 word and writes it into instruction memory at consecutive word addresses. It sits between the bench or boot loader and the imem write port, ahead of the single-cycle core.

## Interface
- ADDR_W, 6: imem word-address width; DEPTH = 2**ADDR_W words.
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin a new program load; clears address and error state.
- finish  in  1  end the load.
- in_valid  in  1  field beat valid.
- in_ready  out  1  beat can be accepted.
- in_op  in  4  instruction class (op_e).
- in_rd  in  5  Rd/Rt.
- in_rn  in  5  Rn.
- in_rm  in  5  Rm.
- in_imm  in  26  signed immediate.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written this load.
- done  out  1  load finished.
- err_pulse  out  1  one-cycle flag: beat rejected.
- err_sticky  out  1  any rejection since start.

## Operation
- States: IDLE (after reset), LOAD, DONE. IDLE/DONE + start -> LOAD (count, err_sticky cleared). LOAD + finish -> DONE. Any other input: hold.
- in_ready = (state == LOAD) && count < DEPTH. Beat accepted when in_valid && in_ready.
- Encodings ([31:21] opcode unless noted):
  - LDUR 11'b11111000010 / STUR 11'b11111000000: imm[8:0] -> [20:12], [11:10]=00, Rn [9:5], Rd(Rt) [4:0].
  - ADD 11'b10001011000, SUB 11'b11001011000, AND 11'b10001010000, ORR 11'b10101010000: Rm [20:16], shamt [15:10]=0, Rn, Rd.
  - CBZ: [31:24]=8'b10110100, imm[18:0] -> [23:5], Rd(Rt) [4:0].
  - B: [31:26]=6'b000101, imm[25:0].
  - BR 11'b11010110000: [20:16]=5'b11111, [15:10]=0, Rn [9:5], [4:0]=0.
- Immediate range: field widths 9 (D-type), 19 (CBZ), 26 (B); imm must sign-extend back from the field width unchanged, otherwise range error. R-type and BR ignore in_imm and in_rm/in_rd as applicable.
- Undefined in_op or range error: beat is still accepted (consumed), no write, count unchanged, err_pulse and err_sticky set.

## Timing
- Reset: state IDLE; in_ready, imem_we, imem_addr, imem_wdata, count, done, err_pulse, err_sticky all 0.
- Latency 1: accepted beat in cycle N -> imem_we=1 in cycle N+1 with imem_addr = count at N, wdata registered; count increments at end of N (visible N+1). Throughput one word/cycle.
- imem_we, err_pulse are single-cycle; imem_addr/wdata hold last value when we=0.
- count == DEPTH: in_ready low, no wrap; beats stall until finish.
- finish with accepted beat same cycle: beat encoded and written in N+1; state DONE at N+1; done=1 from N+1.
- start and finish together: start wins. start in LOAD: ignored.
- done high throughout DONE, cleared on leaving DONE.
- reset low mid-load: outputs to reset values next edge; a pending write is dropped.

## Structure
- Package legv8_pkg: op_e enum (LDUR, STUR, CBZ, ADD, SUB, AND, ORR, B, BR), the 11/8/6-bit opcode constants (shared with the main decoder), field-width constants 9/19/26.
- Sub-module instr_pack: combinational fields -> {word, illegal, range_err}; instr_encoder holds FSM, counter, output registers.

## Test plan
- start; ADD rd=3 rn=1 rm=2 -> next cycle imem_we=1, addr 0, wdata 0x8B020023; count=1.
- LDUR rd=9 rn=22 imm=64 then CBZ rd=5 imm=-2 back-to-back -> 0xF84402C9 @0, 0xB4FFFFC5 @1, consecutive cycles.
- BR rn=30 -> 0xD61F03C0.
- LDUR imm=256 -> no write, err_pulse one cycle, err_sticky=1, count unchanged; new start clears err_sticky.
- ADDR_W=2: 4 beats written @0..3, count=4, in_ready=0 with in_valid held; finish -> done=1, no 5th write.
- reset low one cycle after an accepted beat -> no imem_we, all outputs 0, state IDLE.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding definitions: instruction classes, opcode constants
// (also used by the main decoder), immediate field widths and encoder FSM states.
package legv8_pkg;

    typedef enum logic [3:0] {
        OP_LDUR = 4'd0,
        OP_STUR = 4'd1,
        OP_CBZ  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_AND  = 4'd5,
        OP_ORR  = 4'd6,
        OP_B    = 4'd7,
        OP_BR   = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_BR   = 11'b11010110000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [5:0]  OPC_B    = 6'b000101;

    localparam int IMM_W_D  = 9;
    localparam int IMM_W_CB = 19;
    localparam int IMM_W_B  = 26;

    // True when imm survives truncation to 'width' bits and sign-extension back,
    // i.e. every bit from width-1 upward equals the sign bit.
    function automatic logic imm_fits(input logic [25:0] imm, input int width);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if ((i >= width - 1) && (imm[i] != imm[25])) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: turns an instruction class plus register and
// immediate fields into a 32-bit LEGv8 word, flagging unknown classes and
// immediates that do not fit their encoded field.
module instr_pack
    import legv8_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rn_i,
    input  logic [4:0]  rm_i,
    input  logic [25:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o,
    output logic        range_err_o
);

    // Select the encoding format by class; R-type and BR ignore the immediate.
    always_comb begin
        word_o      = '0;
        illegal_o   = 1'b0;
        range_err_o = 1'b0;
        case (op_i)
            OP_LDUR: begin
                word_o      = {OPC_LDUR, imm_i[8:0], 2'b00, rn_i, rd_i};
                range_err_o = !imm_fits(imm_i, IMM_W_D);
            end
            OP_STUR: begin
                word_o      = {OPC_STUR, imm_i[8:0], 2'b00, rn_i, rd_i};
                range_err_o = !imm_fits(imm_i, IMM_W_D);
            end
            OP_CBZ: begin
                word_o      = {OPC_CBZ, imm_i[18:0], rd_i};
                range_err_o = !imm_fits(imm_i, IMM_W_CB);
            end
            OP_ADD:  word_o = {OPC_ADD, rm_i, 6'b000000, rn_i, rd_i};
            OP_SUB:  word_o = {OPC_SUB, rm_i, 6'b000000, rn_i, rd_i};
            OP_AND:  word_o = {OPC_AND, rm_i, 6'b000000, rn_i, rd_i};
            OP_ORR:  word_o = {OPC_ORR, rm_i, 6'b000000, rn_i, rd_i};
            OP_B: begin
                word_o      = {OPC_B, imm_i};
                range_err_o = !imm_fits(imm_i, IMM_W_B);
            end
            OP_BR:   word_o = {OPC_BR, 5'b11111, 6'b000000, rn_i, 5'b00000};
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential LEGv8 program loader: accepts field beats while loading, packs
// each into an instruction word and writes it to consecutive imem addresses.
// Rejected beats are consumed without a write and raise the error flags.
module instr_encoder
    import legv8_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [25:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err_pulse,
    output logic              err_sticky
);

    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    enc_state_e        state_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              done_q;
    logic              err_pulse_q;
    logic              err_sticky_q;

    logic [31:0]       word;
    logic              illegal;
    logic              range_err;
    logic              accept;

    instr_pack u_pack (
        .op_i        (in_op),
        .rd_i        (in_rd),
        .rn_i        (in_rn),
        .rm_i        (in_rm),
        .imm_i       (in_imm),
        .word_o      (word),
        .illegal_o   (illegal),
        .range_err_o (range_err)
    );

    // Ready only while loading and memory is not yet full; no address wrap.
    assign in_ready = (state_q == ST_LOAD) && (count_q < DEPTH_C);
    assign accept   = in_valid && in_ready;
    assign count_d  = count_q + 1'b1;

    // Load FSM, word counter and registered write/status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            done_q       <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            we_q        <= 1'b0;
            err_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q      <= ST_LOAD;
                        count_q      <= '0;
                        err_sticky_q <= 1'b0;
                        done_q       <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (illegal || range_err) begin
                            err_pulse_q  <= 1'b1;
                            err_sticky_q <= 1'b1;
                        end else begin
                            we_q    <= 1'b1;
                            addr_q  <= count_q[ADDR_W-1:0];
                            wdata_q <= word;
                            count_q <= count_d;
                        end
                    end
                    // A beat accepted alongside finish is still written.
                    if (finish) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign done       = done_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (ADDR_W=2): expected writes are queued when
// a beat is driven and compared by a monitor when imem_we fires.
module tb_instr_encoder;
    import legv8_pkg::*;

    localparam int AW = 2;

    logic          clk;
    logic          reset;
    logic          start;
    logic          finish;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [4:0]    in_rd;
    logic [4:0]    in_rn;
    logic [4:0]    in_rm;
    logic [25:0]   in_imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          done;
    logic          err_pulse;
    logic          err_sticky;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .finish     (finish),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rn      (in_rn),
        .in_rm      (in_rm),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .done       (done),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [25:0] imm);
        in_op    = op;
        in_rd    = rd;
        in_rn    = rn;
        in_rm    = rm;
        in_imm   = imm;
        in_valid = 1'b1;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && imem_we) begin
            check("sb_has_entry", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("wr_addr", 64'(imem_addr), 64'(e.addr));
                check("wr_data", 64'(imem_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        reset = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        in_op = '0; in_rd = '0; in_rn = '0; in_rm = '0; in_imm = '0;
        step(); step(); step();
        check("rst_ready",  64'(in_ready),   64'd0);
        check("rst_we",     64'(imem_we),    64'd0);
        check("rst_addr",   64'(imem_addr),  64'd0);
        check("rst_wdata",  64'(imem_wdata), 64'd0);
        check("rst_count",  64'(count),      64'd0);
        check("rst_done",   64'(done),       64'd0);
        check("rst_epulse", 64'(err_pulse),  64'd0);
        check("rst_sticky", 64'(err_sticky), 64'd0);
        reset = 1'b1;
        step();
        check("idle_ready", 64'(in_ready), 64'd0);

        // Load 1: single ADD
        start = 1'b1; step(); start = 1'b0;
        check("load_ready", 64'(in_ready), 64'd1);
        beat(OP_ADD, 5'd3, 5'd1, 5'd2, 26'd0); expect_wr(2'd0, 32'h8B020023);
        step(); in_valid = 1'b0;
        check("add_we",    64'(imem_we), 64'd1);
        check("add_count", 64'(count),   64'd1);
        step();
        check("we_single", 64'(imem_we), 64'd0);
        finish = 1'b1; step(); finish = 1'b0;
        check("fin_done",  64'(done),     64'd1);
        check("fin_ready", 64'(in_ready), 64'd0);

        // Load 2: back-to-back, start ignored in LOAD, hold, range errors
        start = 1'b1; step(); start = 1'b0;
        check("restart_count", 64'(count), 64'd0);
        check("restart_done",  64'(done),  64'd0);
        beat(OP_LDUR, 5'd9, 5'd22, 5'd0, 26'd64);        expect_wr(2'd0, 32'hF84402C9);
        step();
        check("ldur_we", 64'(imem_we), 64'd1);
        beat(OP_CBZ, 5'd5, 5'd0, 5'd0, 26'h3FFFFFE);     expect_wr(2'd1, 32'hB4FFFFC5);
        step(); in_valid = 1'b0;
        check("cbz_we_consec", 64'(imem_we), 64'd1);
        check("cbz_count",     64'(count),   64'd2);
        start = 1'b1; step(); start = 1'b0;
        check("start_in_load_count", 64'(count),    64'd2);
        check("start_in_load_ready", 64'(in_ready), 64'd1);
        beat(OP_BR, 5'd0, 5'd30, 5'd0, 26'd0);           expect_wr(2'd2, 32'hD61F03C0);
        step(); in_valid = 1'b0;
        step();
        check("hold_we",    64'(imem_we),    64'd0);
        check("hold_addr",  64'(imem_addr),  64'd2);
        check("hold_wdata", 64'(imem_wdata), 64'hD61F03C0);
        beat(OP_LDUR, 5'd1, 5'd1, 5'd0, 26'd256);
        step();
        check("rng_we",     64'(imem_we),    64'd0);
        check("rng_epulse", 64'(err_pulse),  64'd1);
        check("rng_sticky", 64'(err_sticky), 64'd1);
        check("rng_count",  64'(count),      64'd3);
        beat(4'd9, 5'd1, 5'd1, 5'd1, 26'd0);
        step();
        check("undef_epulse", 64'(err_pulse), 64'd1);
        check("undef_we",     64'(imem_we),   64'd0);
        beat(OP_CBZ, 5'd2, 5'd0, 5'd0, 26'h0040000);
        step();
        check("cbz_rng_epulse", 64'(err_pulse), 64'd1);
        check("cbz_rng_count",  64'(count),     64'd3);
        beat(OP_LDUR, 5'd0, 5'd0, 5'd0, 26'h3FFFF00);    expect_wr(2'd3, 32'hF8500000);
        step(); in_valid = 1'b0;
        check("ldur_neg_we",     64'(imem_we),   64'd1);
        check("ldur_neg_epulse", 64'(err_pulse), 64'd0);
        check("ldur_neg_count",  64'(count),     64'd4);
        step();
        check("epulse_clear", 64'(err_pulse),  64'd0);
        check("sticky_holds", 64'(err_sticky), 64'd1);
        finish = 1'b1; step(); finish = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        check("start_clr_sticky", 64'(err_sticky), 64'd0);
        check("start_clr_count",  64'(count),      64'd0);

        // Load 3: beat accepted in the same cycle as finish
        beat(OP_STUR, 5'd1, 5'd2, 5'd0, 26'h3FFFFFF);    expect_wr(2'd0, 32'hF81FF041);
        finish = 1'b1; step(); finish = 1'b0; in_valid = 1'b0;
        check("finbeat_we",    64'(imem_we), 64'd1);
        check("finbeat_done",  64'(done),    64'd1);
        check("finbeat_count", 64'(count),   64'd1);

        // Load 4: start+finish together (start wins), then fill to DEPTH
        start = 1'b1; finish = 1'b1; step(); start = 1'b0; finish = 1'b0;
        check("sf_done",  64'(done),     64'd0);
        check("sf_ready", 64'(in_ready), 64'd1);
        beat(OP_SUB, 5'd4, 5'd5, 5'd6, 26'd0);           expect_wr(2'd0, 32'hCB0600A4);
        step();
        beat(OP_AND, 5'd7, 5'd8, 5'd9, 26'd0);           expect_wr(2'd1, 32'h8A090107);
        step();
        beat(OP_ORR, 5'd10, 5'd11, 5'd12, 26'd0);        expect_wr(2'd2, 32'hAA0C016A);
        step();
        beat(OP_B, 5'd0, 5'd0, 5'd0, 26'h3FFFFFC);       expect_wr(2'd3, 32'h17FFFFFC);
        step();
        check("full_count", 64'(count),    64'd4);
        check("full_ready", 64'(in_ready), 64'd0);
        beat(OP_ADD, 5'd1, 5'd1, 5'd1, 26'd0);
        step();
        check("stall_we",    64'(imem_we), 64'd0);
        check("stall_count", 64'(count),   64'd4);
        step();
        check("stall2_we", 64'(imem_we), 64'd0);
        finish = 1'b1; step(); finish = 1'b0;
        check("full_fin_done", 64'(done),    64'd1);
        check("full_fin_we",   64'(imem_we), 64'd0);
        in_valid = 1'b0;
        step();
        check("sb_drained", 64'(sb.size()), 64'd0);

        // Reset during load drops the pending write
        start = 1'b1; step(); start = 1'b0;
        beat(OP_ADD, 5'd3, 5'd1, 5'd2, 26'd0);
        reset = 1'b0;
        step(); in_valid = 1'b0;
        check("mid_rst_we",     64'(imem_we),    64'd0);
        check("mid_rst_addr",   64'(imem_addr),  64'd0);
        check("mid_rst_wdata",  64'(imem_wdata), 64'd0);
        check("mid_rst_count",  64'(count),      64'd0);
        check("mid_rst_done",   64'(done),       64'd0);
        check("mid_rst_sticky", 64'(err_sticky), 64'd0);
        check("mid_rst_ready",  64'(in_ready),   64'd0);
        reset = 1'b1;
        step();
        check("post_rst_idle_ready", 64'(in_ready), 64'd0);
        check("post_rst_we",         64'(imem_we),  64'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
